fft_frame_scheduler: RTL and testbench
======================================

Name: fft_frame_scheduler

Overview:
- Shares one 8-point DFT engine between two AXI-Stream requester channels (ch0, ch1).
- Round-robin arbitration with packet-level grant locking: a channel keeps the grant until its tlast beat is accepted.
- A tag FIFO records the channel of every frame issued to the engine, so each 512-bit result returns to the channel that sent it.
- Sits between the sample framers and the fft_8point_dft instance.

Parameters:
- DATA_W, 64, input frame width (8 x Q7 samples).
- RES_W, 512, engine result width (8 x {32b real, 32b imag}).
- TAG_DEPTH, 8, tag FIFO depth, power of 2, >= 2; limits frames in flight inside the engine.

Ports:
- s_axis_aclk  in  1  clock
- s_axis_aresetn  in  1  synchronous active-low reset
- s0_axis_tvalid/s1_axis_tvalid  in  1  requester frame valid
- s0_axis_tready/s1_axis_tready  out  1  requester frame ready
- s0_axis_tdata/s1_axis_tdata  in  DATA_W  requester frame
- s0_axis_tlast/s1_axis_tlast  in  1  last frame of packet
- eng_s_tvalid  out  1  frame valid to engine
- eng_s_tready  in  1  engine ready
- eng_s_tdata  out  DATA_W  frame to engine
- eng_m_tvalid  in  1  engine result valid
- eng_m_tready  out  1  result accept
- eng_m_tdata  in  RES_W  engine result
- m0_axis_tvalid/m1_axis_tvalid  out  1  result valid per channel
- m0_axis_tready/m1_axis_tready  in  1  downstream ready per channel
- m0_axis_tdata/m1_axis_tdata  out  RES_W  result per channel (both carry eng_m_tdata)
- tag_err  out  1  sticky error flag

Behaviour:
- Reset (s_axis_aresetn low at a clock edge, honoured mid-operation):
  - State returns to IDLE, FIFO count and pointers go to 0, rr_prio goes to 0 (ch0 preferred), tag_err clears.
  - All tvalid and tready outputs are 0 while in reset.
  - Any in-flight tags are discarded. Results the engine emits afterwards with the FIFO empty set tag_err.
- State machine IDLE / GRANT0 / GRANT1:
  - IDLE: if exactly one sN_axis_tvalid is high, go to GRANTN. If both are high, grant the channel selected by rr_prio. The grant registers on the next edge; no frame is issued from IDLE.
  - GRANTN: on an issue handshake with sN_axis_tlast=1, go to IDLE and set rr_prio to the other channel. Otherwise stay in GRANTN, even while sN_axis_tvalid is low.
- Issue path (combinational, 0-cycle):
  - eng_s_tvalid = granted sN_axis_tvalid AND NOT tag_full.
  - eng_s_tdata = granted sN_axis_tdata.
  - sN_axis_tready = granted AND eng_s_tready AND NOT tag_full. The non-granted channel's tready is 0.
  - A handshake (eng_s_tvalid AND eng_s_tready) pushes the channel id into the tag FIFO.
- Return path (combinational, 0-cycle):
  - Let h be the FIFO head.
  - mh_axis_tvalid = eng_m_tvalid AND NOT tag_empty. The other channel's tvalid is 0.
  - eng_m_tready = NOT tag_empty AND mh_axis_tready.
  - A handshake on the engine result pops the FIFO.
  - Back-pressure on one channel stalls results for both channels, because results stay in order.
- FIFO rules:
  - tag_full and tag_empty are derived from the registered count only.
  - Push and pop in the same cycle leave the count unchanged. This is legal when full, but the push is blocked that cycle because full is evaluated at the start of the cycle.
  - Pointers wrap modulo TAG_DEPTH.
- Error: eng_m_tvalid=1 while the FIFO is empty sets tag_err; it stays set until reset. The result is not accepted (eng_m_tready=0).

Optional Feature:
- Macro: FFT_SCHED_STATS_EN.
- When defined, add outputs frames0_cnt[15:0] and frames1_cnt[15:0]. Each increments on its channel's mN_axis handshake, wraps 0xFFFF to 0, and resets to 0.
- When undefined, these ports and counters do not exist.

Test Plan:
- Single channel: ch0 sends 3 frames with tlast on the third, engine ready, results returned in order -> 3 issues with data unchanged, tags {0,0,0}, m0 receives 3 results, m1_axis_tvalid stays 0.
- Contention: both channels hold tvalid, 2-frame packets each, starting from reset -> order ch0,ch0,ch1,ch1,ch0,ch0; the non-granted channel's tready is 0 throughout.
- FIFO full: TAG_DEPTH=8, engine returns no results, ch1 streams 10 frames -> exactly 8 issued, then s1_axis_tready=0. Return one result -> the 9th frame issues on the following cycle.
- Back-pressure: head tag=0 with m0_axis_tready=0 while m1_axis_tready=1 -> eng_m_tready=0 and nothing reaches m1 until m0 accepts.
- Error and reset: eng_m_tvalid pulsed while the FIFO is empty -> tag_err=1 and stays 1. Assert reset mid-packet -> state IDLE, tag_err=0, all valids 0 on the next cycle.
- With FFT_SCHED_STATS_EN: 5 results to m0 and 2 to m1 -> frames0_cnt=5 and frames1_cnt=2. Preload 0xFFFF and deliver one result -> the counter reads 0.

Source files
------------

// File: rtl/fft_frame_scheduler.sv
// Two-channel AXI-Stream frame scheduler sharing one 8-point DFT engine, with
// packet-locked round-robin issue and a tag FIFO steering results back. Optional counters: FFT_SCHED_STATS_EN.
module fft_frame_scheduler #(
  parameter int DATA_W    = 64,
  parameter int RES_W     = 512,
  parameter int TAG_DEPTH = 8
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_aresetn,
  input  logic              s0_axis_tvalid,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic              s0_axis_tlast,
  input  logic              s1_axis_tvalid,
  output logic              s1_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic              s1_axis_tlast,
  output logic              eng_s_tvalid,
  input  logic              eng_s_tready,
  output logic [DATA_W-1:0] eng_s_tdata,
  input  logic              eng_m_tvalid,
  output logic              eng_m_tready,
  input  logic [RES_W-1:0]  eng_m_tdata,
  output logic              m0_axis_tvalid,
  input  logic              m0_axis_tready,
  output logic [RES_W-1:0]  m0_axis_tdata,
  output logic              m1_axis_tvalid,
  input  logic              m1_axis_tready,
  output logic [RES_W-1:0]  m1_axis_tdata,
  output logic              tag_err
`ifdef FFT_SCHED_STATS_EN
  ,
  output logic [15:0]       frames0_cnt,
  output logic [15:0]       frames1_cnt
`endif
);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t               state_q, state_d;
  logic                 rr_prio_q, rr_prio_d;
  logic [TAG_DEPTH-1:0] tag_mem_q;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PW:0]          cnt_q;
  logic                 tag_err_q;

  logic tag_full, tag_empty, head, gnt0, gnt1, push, pop, last_g;

  assign tag_full  = (cnt_q == FULL_CNT);
  assign tag_empty = (cnt_q == '0);
  assign head      = tag_mem_q[rd_ptr_q];
  assign gnt0      = (state_q == GRANT0);
  assign gnt1      = (state_q == GRANT1);
  assign last_g    = gnt1 ? s1_axis_tlast : s0_axis_tlast;

  // Outputs are gated by reset so nothing handshakes while reset is held.
  assign eng_s_tvalid   = s_axis_aresetn & ~tag_full &
                          ((gnt0 & s0_axis_tvalid) | (gnt1 & s1_axis_tvalid));
  assign eng_s_tdata    = gnt1 ? s1_axis_tdata : s0_axis_tdata;
  assign s0_axis_tready = s_axis_aresetn & gnt0 & eng_s_tready & ~tag_full;
  assign s1_axis_tready = s_axis_aresetn & gnt1 & eng_s_tready & ~tag_full;
  assign push           = eng_s_tvalid & eng_s_tready;

  // Results leave strictly in issue order, so the head's channel gates both.
  assign m0_axis_tvalid = s_axis_aresetn & eng_m_tvalid & ~tag_empty & ~head;
  assign m1_axis_tvalid = s_axis_aresetn & eng_m_tvalid & ~tag_empty & head;
  assign m0_axis_tdata  = eng_m_tdata;
  assign m1_axis_tdata  = eng_m_tdata;
  assign eng_m_tready   = s_axis_aresetn & ~tag_empty &
                          (head ? m1_axis_tready : m0_axis_tready);
  assign pop            = eng_m_tvalid & eng_m_tready;
  assign tag_err        = tag_err_q;

  always_comb begin
    state_d   = state_q;
    rr_prio_d = rr_prio_q;
    case (state_q)
      IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid) state_d = rr_prio_q ? GRANT1 : GRANT0;
        else if (s0_axis_tvalid)              state_d = GRANT0;
        else if (s1_axis_tvalid)              state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (push && last_g) begin
          state_d   = IDLE;
          rr_prio_d = gnt0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      state_q   <= IDLE;
      rr_prio_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      tag_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_prio_q <= rr_prio_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (PW+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (PW+1)'(1);
      if (eng_m_tvalid && tag_empty) tag_err_q <= 1'b1;
    end
  end

  // Tag storage needs no reset: only entries between the pointers are read.
  always_ff @(posedge s_axis_aclk) begin
    if (push) tag_mem_q[wr_ptr_q] <= gnt1;
  end

`ifdef FFT_SCHED_STATS_EN
  logic [15:0] frames0_q, frames1_q;
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      frames0_q <= '0;
      frames1_q <= '0;
    end else begin
      if (m0_axis_tvalid && m0_axis_tready) frames0_q <= frames0_q + 16'd1;
      if (m1_axis_tvalid && m1_axis_tready) frames1_q <= frames1_q + 16'd1;
    end
  end
  assign frames0_cnt = frames0_q;
  assign frames1_cnt = frames1_q;
`endif

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Randomized + directed bench for fft_frame_scheduler against a queue-based
// transaction model of grant, tag ordering and error rules.
module tb_fft_frame_scheduler;
  localparam int DW = 64, RW = 512, TD = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          s0v, s0r, s0l, s1v, s1r, s1l;
  logic [DW-1:0] s0d, s1d, esd;
  logic          esv, esr, emv, emr, m0v, m0r, m1v, m1r, terr;
  logic [RW-1:0] emd, m0d, m1d;
`ifdef FFT_SCHED_STATS_EN
  logic [15:0]   f0c, f1c;
`endif

  fft_frame_scheduler #(.DATA_W(DW), .RES_W(RW), .TAG_DEPTH(TD)) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rstn),
    .s0_axis_tvalid(s0v), .s0_axis_tready(s0r), .s0_axis_tdata(s0d), .s0_axis_tlast(s0l),
    .s1_axis_tvalid(s1v), .s1_axis_tready(s1r), .s1_axis_tdata(s1d), .s1_axis_tlast(s1l),
    .eng_s_tvalid(esv), .eng_s_tready(esr), .eng_s_tdata(esd),
    .eng_m_tvalid(emv), .eng_m_tready(emr), .eng_m_tdata(emd),
    .m0_axis_tvalid(m0v), .m0_axis_tready(m0r), .m0_axis_tdata(m0d),
    .m1_axis_tvalid(m1v), .m1_axis_tready(m1r), .m1_axis_tdata(m1d),
    .tag_err(terr)
`ifdef FFT_SCHED_STATS_EN
    , .frames0_cnt(f0c), .frames1_cnt(f1c)
`endif
  );

  // Staged stimulus, applied to the DUT at the falling edge
  bit            r_rstn, r_esr, r_emv;
  bit            r_sv[2], r_sl[2], r_mr[2];
  logic [DW-1:0] r_sd[2];
  logic [RW-1:0] r_emd;

  // Transaction model
  int gnt, sent[2], recv[2], nissued, cnt[2];
  bit prio, err;
  int q[$], log_q[$];

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    gnt = -1; prio = 0; err = 0; q.delete(); log_q.delete();
    sent = '{0, 0}; recv = '{0, 0}; cnt = '{0, 0}; nissued = 0;
  endtask

  task automatic step();
    bit full, empty, e_esv, e_sr0, e_sr1, e_m0v, e_m1v, e_emr, issue, pop;
    int h;
    @(negedge clk);
    rstn = r_rstn; esr = r_esr; emv = r_emv; emd = r_emd;
    s0v = r_sv[0]; s0l = r_sl[0]; s0d = r_sd[0]; m0r = r_mr[0];
    s1v = r_sv[1]; s1l = r_sl[1]; s1d = r_sd[1]; m1r = r_mr[1];
    #1;
    full  = (q.size() == TD);
    empty = (q.size() == 0);
    h     = empty ? 0 : q[0];
    e_esv = 0; e_sr0 = 0; e_sr1 = 0; e_m0v = 0; e_m1v = 0; e_emr = 0;
    if (r_rstn) begin
      e_esv = (gnt >= 0) && r_sv[gnt] && !full;
      e_sr0 = (gnt == 0) && r_esr && !full;
      e_sr1 = (gnt == 1) && r_esr && !full;
      e_m0v = r_emv && !empty && (h == 0);
      e_m1v = r_emv && !empty && (h == 1);
      e_emr = !empty && r_mr[h];
    end
    chk("eng_s_tvalid", esv, e_esv);
    chk("s0_tready", s0r, e_sr0);
    chk("s1_tready", s1r, e_sr1);
    chk("m0_tvalid", m0v, e_m0v);
    chk("m1_tvalid", m1v, e_m1v);
    chk("eng_m_tready", emr, e_emr);
    if (r_rstn) chk("tag_err", terr, err);
    if (e_esv) chk("eng_s_tdata", esd, r_sd[gnt]);
    if (e_m0v) chk("m0_tdata", m0d, r_emd);
    if (e_m1v) chk("m1_tdata", m1d, r_emd);
`ifdef FFT_SCHED_STATS_EN
    if (r_rstn) begin
      chk("frames0_cnt", f0c, cnt[0]);
      chk("frames1_cnt", f1c, cnt[1]);
    end
`endif
    issue = e_esv && r_esr;
    pop   = r_emv && e_emr;
    @(posedge clk);
    if (!r_rstn) model_reset();
    else begin
      if (r_emv && empty) err = 1;
      if (pop) begin
        recv[h]++; cnt[h] = (cnt[h] + 1) % 65536; void'(q.pop_front());
      end
      if (issue) begin
        q.push_back(gnt); log_q.push_back(gnt); sent[gnt]++; nissued++;
        if (r_sl[gnt]) begin prio = (gnt == 0); gnt = -1; end
      end else if (gnt < 0) begin
        if (r_sv[0] && r_sv[1]) gnt = prio ? 1 : 0;
        else if (r_sv[0])       gnt = 0;
        else if (r_sv[1])       gnt = 1;
      end
    end
  endtask

  task automatic idle_inputs();
    r_rstn = 1; r_esr = 0; r_emv = 0; r_emd = '0;
    r_sv = '{0, 0}; r_sl = '{0, 0}; r_mr = '{0, 0};
  endtask

  task automatic do_reset();
    idle_inputs();
    r_rstn = 0; r_sv = '{1, 1}; r_mr = '{1, 1}; r_emv = 1; r_esr = 1;
    step(); step();
    idle_inputs();
  endtask

  task automatic rand_data();
    r_sd[0] = {$urandom, $urandom};
    r_sd[1] = {$urandom, $urandom};
    for (int k = 0; k < RW/32; k++) r_emd[k*32 +: 32] = $urandom;
  endtask

  initial begin
    model_reset();
    idle_inputs();
    r_sd = '{64'h0, 64'h0};
    do_reset();
    step();

    // Single channel: 3-frame packet on ch0, then return the 3 results
    for (int i = 0; i < 6 && sent[0] < 3; i++) begin
      rand_data(); r_sv[0] = 1; r_sl[0] = (sent[0] == 2); r_esr = 1; step();
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      rand_data(); r_emv = 1; r_mr = '{1, 0}; step();
    end
    idle_inputs(); step();
    chk("single_issued", nissued, 3);
    chk("single_m0_recv", recv[0], 3);
    chk("single_m1_recv", recv[1], 0);

    // Contention: 2-frame packets on both channels from reset
    do_reset();
    for (int i = 0; i < 14; i++) begin
      rand_data(); r_sv = '{1, 1}; r_esr = 1;
      r_sl[0] = sent[0][0]; r_sl[1] = sent[1][0];
      r_emv = (q.size() > 0); r_mr = '{1, 1}; step();
    end
    chk("contend_len", (log_q.size() >= 6), 1);
    if (log_q.size() >= 6) begin
      chk("contend_o0", log_q[0], 0); chk("contend_o1", log_q[1], 0);
      chk("contend_o2", log_q[2], 1); chk("contend_o3", log_q[3], 1);
      chk("contend_o4", log_q[4], 0); chk("contend_o5", log_q[5], 0);
    end

    // FIFO full: ch1 streams, no results, then a single pop
    do_reset();
    for (int i = 0; i < 12; i++) begin
      rand_data(); r_sv[1] = 1; r_esr = 1; step();
    end
    chk("full_issued8", nissued, 8);
    r_emv = 1; r_mr = '{0, 1}; step();
    r_emv = 0; step();
    chk("full_issued9", nissued, 9);

    // Back-pressure: head tag 0 stalled while ch1 is ready
    do_reset();
    r_sv[0] = 1; r_sl[0] = 1; r_esr = 1; step(); step();
    r_sv[0] = 0; r_sv[1] = 1; r_sl[1] = 1; step(); step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      rand_data(); r_emv = 1; r_mr = '{0, 1}; step();
    end
    chk("bp_m1_none", recv[1], 0);
    chk("bp_q_depth", q.size(), 2);
    r_mr = '{1, 1}; step(); step();
    chk("bp_drained0", recv[0], 1);
    chk("bp_drained1", recv[1], 1);
    idle_inputs();

    // Error flag is sticky; reset mid-packet clears everything
    do_reset();
    r_emv = 1; step();
    r_emv = 0; step(); step(); step();
    chk("err_sticky", terr, 1);
    r_sv[0] = 1; r_esr = 1; step(); step(); step();
    r_rstn = 0; step();
    r_rstn = 1; step();
    chk("rst_tag_err", terr, 0);
    chk("rst_s0_tready", s0r, 0);
    idle_inputs();

`ifdef FFT_SCHED_STATS_EN
    // 5 results to ch0, 2 to ch1, then run ch0 up to the counter wrap
    do_reset();
    for (int i = 0; i < 40 && (recv[0] + recv[1]) < 7; i++) begin
      rand_data(); r_esr = 1; r_mr = '{1, 1}; r_emv = (q.size() > 0);
      r_sv[0] = (sent[0] < 5); r_sl[0] = (sent[0] == 4);
      r_sv[1] = (sent[0] >= 5) && (sent[1] < 2); r_sl[1] = (sent[1] == 1);
      step();
    end
    idle_inputs(); step();
    chk("stats_f0_5", f0c, 5);
    chk("stats_f1_2", f1c, 2);
    for (int i = 0; i < 70000 && cnt[0] != 65535; i++) begin
      r_sv[0] = 1; r_sl[0] = 0; r_esr = 1; r_mr = '{1, 1}; r_emv = (q.size() > 0);
      step();
    end
    idle_inputs(); step();
    chk("stats_f0_ffff", f0c, 16'hFFFF);
    r_emv = (q.size() > 0); r_mr = '{1, 1}; step();
    idle_inputs(); step();
    chk("stats_f0_wrap", f0c, 0);
`endif

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_data();
      r_sv[0] = $urandom_range(0, 3) != 0; r_sv[1] = $urandom_range(0, 3) != 0;
      r_sl[0] = $urandom_range(0, 2) == 0; r_sl[1] = $urandom_range(0, 2) == 0;
      r_esr   = $urandom_range(0, 3) != 0;
      r_emv   = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      r_mr[0] = $urandom_range(0, 3) != 0; r_mr[1] = $urandom_range(0, 3) != 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
